iiitb_uart_rx: RTL

IIITB_UART_RX -- requirements
Module: iiitb_uart_rx

---
 rtl/iiitb_uart_pkg.sv | 41 ++++
 rtl/iiitb_uart_baud_timer.sv | 53 +++++
 rtl/iiitb_uart_rx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/iiitb_uart_pkg.sv
// Shared constants and types for the iiitb UART receiver.
// UART_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package iiitb_uart_pkg;

    localparam int unsigned CNT_W = 14;

    // Bit periods in 125 MHz clock cycles
    localparam logic [CNT_W-1:0] BIT_PER_115200 = 14'd1085;
    localparam logic [CNT_W-1:0] BIT_PER_38400  = 14'd3255;
    localparam logic [CNT_W-1:0] BIT_PER_19200  = 14'd6510;
    localparam logic [CNT_W-1:0] BIT_PER_9600   = 14'd13021;

    typedef enum logic [1:0] {
        SEL_115200 = 2'b00,
        SEL_38400  = 2'b01,
        SEL_19200  = 2'b10,
        SEL_9600   = 2'b11
    } baud_sel_e;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP
    } rx_state_e;
`endif

    function automatic logic [CNT_W-1:0] bit_period(input baud_sel_e s);
        logic [CNT_W-1:0] p;
        case (s)
            SEL_115200: p = BIT_PER_115200;
            SEL_38400:  p = BIT_PER_38400;
            SEL_19200:  p = BIT_PER_19200;
            default:    p = BIT_PER_9600;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/iiitb_uart_baud_timer.sv
// Bit-period timer: after start_i, one half_tick at mid start bit, then a
// full_tick every bit period. clear_i holds the counter at zero while idle.
module iiitb_uart_baud_timer
    import iiitb_uart_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  baud_sel_e sel_i,
    input  logic      start_i,
    input  logic      clear_i,
    output logic      half_tick_o,
    output logic      full_tick_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             half_ph_q, half_ph_d;
    logic [CNT_W-1:0] period, half;

    always_comb begin
        period      = bit_period(sel_i);
        half        = period >> 1;
        half_tick_o = half_ph_q && (cnt_q == half - ONE);
        full_tick_o = !half_ph_q && (cnt_q == period - ONE);
        cnt_d       = cnt_q + ONE;
        half_ph_d   = half_ph_q;
        // Every sample point reloads, so the count never passes one bit
        if (half_tick_o || full_tick_o) begin
            cnt_d     = '0;
            half_ph_d = 1'b0;
        end
        if (clear_i) begin
            cnt_d     = '0;
            half_ph_d = 1'b0;
        end
        if (start_i) begin
            cnt_d     = '0;
            half_ph_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            half_ph_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_ph_q <= half_ph_d;
        end
    end

endmodule

// File: rtl/iiitb_uart_rx.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), valid/ready output with
// single-byte holding register; frame_err/overrun(/parity_err) are 1-cycle pulses.
module iiitb_uart_rx
    import iiitb_uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
   ,output logic       parity_err
`endif
);

    logic      rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic      fall;
    rx_state_e state_q, state_d;
    baud_sel_e sel_q, sel_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic      rx_valid_q, rx_valid_d;
    logic      frame_err_q, frame_err_d;
    logic      overrun_q, overrun_d;
    logic      tmr_start, tmr_clear, half_tick, full_tick;
`ifdef UART_RX_PARITY_EN
    logic      par_bad_q, par_bad_d;
    logic      parity_err_q, parity_err_d;
`endif

    // Synchronizer plus one history flop for edge detection; idle-high reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign fall      = rxd_prev_q & ~rxd_sync_q;
    assign tmr_clear = (state_q == ST_IDLE);

    iiitb_uart_baud_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .sel_i       (sel_q),
        .start_i     (tmr_start),
        .clear_i     (tmr_clear),
        .half_tick_o (half_tick),
        .full_tick_o (full_tick)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        tmr_start   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d   = ST_START;
                    sel_d     = baud_sel_e'(sel);
                    tmr_start = 1'b1;
                end
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was a glitch
                if (half_tick) begin
                    state_d   = rxd_sync_q ? ST_IDLE : ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (full_tick) begin
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_tick) begin
                    par_bad_d = ^{rxd_sync_q, shift_q};
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (full_tick) begin
                    state_d = ST_IDLE;
                    if (!rxd_sync_q) begin
                        frame_err_d = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end
`endif
                    else if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_115200;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
